vram_slot_sequencer: RTL
========================

Name: vram_slot_sequencer

Overview:
- Time-slot controller for the shared video RAM in the tile/character path.
- Splits each 8-pixel character cell into fixed phases. Video fetch gets the tile-code and attribute slots; the CPU gets the remaining slots and is held off with a Z80-style wait until its slot arrives.
- Drives the latch strobes for the code/attribute register stages (273-style) and the active-low parallel-load of the pixel shifter (166-style).
- Sits between the CPU bus decode, the video address counters and the VRAM.

Parameters:
- ADDR_W, 10, VRAM address width for vid_addr, cpu_addr and ram_addr.

Ports:
- clk  in  1  master clock; all state changes on the rising edge.
- n_clr  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable, one clk wide; phase advances only on pix_ce.
- line_start  in  1  sampled with pix_ce; forces the next phase to 0.
- blank  in  1  video blanking; 1 = no video fetch.
- vid_addr  in  ADDR_W  video fetch address from the H/V counters.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_req  in  1  CPU VRAM request, level, held until cpu_ack.
- cpu_we  in  1  CPU write (1) / read (0), valid with cpu_req.
- ram_addr  out  ADDR_W  VRAM address: cpu_addr_q when ram_sel=1, else vid_addr.
- ram_sel  out  1  0 = video owns VRAM, 1 = CPU owns VRAM.
- ram_we  out  1  VRAM write strobe.
- code_ld  out  1  tile-code latch strobe, one clk pulse.
- attr_ld  out  1  attribute latch strobe, one clk pulse.
- shift_ld_n  out  1  pixel shifter parallel load, active low.
- cpu_ack  out  1  CPU access complete.
- n_wait  out  1  CPU wait, active low.

Behaviour:
- Reset (n_clr=0, asynchronous, any state):
  - phase=0, FSM=IDLE, ram_sel=0, ram_we=0, code_ld=0, attr_ld=0, shift_ld_n=1, cpu_ack=0.
  - n_wait = ~cpu_req.
  - Reset mid-access aborts that access; no write completes after reset asserts.
- Phase counter (3 bits):
  - Changes only on clk edges with pix_ce=1: np = line_start ? 0 : phase+1, wrapping 7->0.
  - When pix_ce=0, all state holds except the strobe clears and DONE->IDLE described below.
- Slot map (blank=0):
  - Phase 0: video code fetch.
  - Phase 1: code latch.
  - Phase 2: video attribute fetch.
  - Phase 3: attribute latch.
  - Phases 4-6: CPU-eligible.
  - Phase 7: shifter load, VRAM idle.
- Strobes, all registered:
  - code_ld=1 for the single clk following the pix_ce edge leaving phase 1 (phase==1 && pix_ce).
  - attr_ld likewise, leaving phase 3.
  - Both are suppressed when blank=1 at that edge.
  - shift_ld_n=0 for the whole of phase 7 when blank=0; otherwise 1.
- CPU FSM states: IDLE, ACCESS, DONE.
  - IDLE->ACCESS: on a pix_ce edge with cpu_req=1 and np CPU-eligible.
    - Captures cpu_addr into cpu_addr_q and cpu_we.
    - Sets ram_sel=1 and ram_we=cpu_we for exactly one pixel period (the phase np).
  - ACCESS->DONE: on the next pix_ce edge.
    - ram_sel=0, ram_we=0, cpu_ack=1.
    - Read data is valid on VRAM at that edge.
  - DONE->IDLE: on the first clk edge with cpu_req=0; cpu_ack drops there. DONE holds while cpu_req=1.
  - A new request is considered only from IDLE, so each request gets at most one access.
- n_wait (combinational) = ~(cpu_req && FSM!=DONE).
- Boundary cases:
  - Grant into phase 6 completes at the 6->7 edge; phase 7 never carries an access start.
  - line_start during ACCESS: the access still ends at the next pix_ce.
  - blank changing mid-access has no effect on the access.
  - cpu_req dropped during ACCESS: the access completes, DONE lasts one clk with cpu_ack=1, then IDLE.
  - cpu_addr/cpu_we changes during ACCESS are ignored because they are latched at grant.
  - Simultaneous line_start and grant: eligibility is evaluated on np=0, so the request is not granted unless blank=1 with the feature enabled.

Optional Feature:
- Macro: FREE_BLANK_ACCESS_EN.
- Defined: when blank=1, all phases 0-7 are CPU-eligible, giving back-to-back CPU access during blanking.
- Undefined: CPU-eligible phases are 4-6 only, regardless of blank; only the strobes are suppressed during blank.

Test Plan:
- Reset with cpu_req=1 -> ram_sel=0, ram_we=0, shift_ld_n=1, cpu_ack=0, n_wait=0. Release n_clr, then 8 pix_ce with blank=0 -> code_ld pulse after phase 1, attr_ld pulse after phase 3, shift_ld_n=0 during phase 7.
- blank=0, cpu_req=1, cpu_we=1, cpu_addr=0x2A5 raised in phase 1 -> n_wait=0 until phase 4. ram_sel=1, ram_addr=0x2A5, ram_we=1 for phase 4 only. cpu_ack=1 from the 4->5 edge. n_wait=1 in DONE.
- Request raised in phase 6 -> granted in phase 4 of the next cell. Request raised in phase 5 -> granted into phase 6, ends at the 6->7 edge, no access in phase 7.
- blank=1, request in phase 0 -> with FREE_BLANK_ACCESS_EN, access in phase 1; without it, access in phase 4. code_ld=0, attr_ld=0, shift_ld_n=1 throughout.
- Request dropped mid-ACCESS, and a second request held high through DONE -> exactly one access each; no second grant until cpu_req=0 for ≥1 clk.
- n_clr asserted during an ACCESS with ram_we=1 -> ram_we=0 and ram_sel=0 immediately, without a clk edge; FSM=IDLE after release.

Source files
------------

// File: rtl/vram_slot_sequencer.sv
// Purpose: time-slot sequencer for the shared tile/character VRAM, with video fetch slots, CPU slots and latch/shifter strobes.
// Latency: a CPU grant owns VRAM for one pixel period; cpu_ack rises at the pix_ce edge that ends that period.
// Backpressure: the CPU is held with n_wait low until its slot completes, and cpu_ack holds until cpu_req drops.
// Optional: define FREE_BLANK_ACCESS_EN to make every phase CPU-eligible while blank=1.
module vram_slot_sequencer #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              n_clr,
   input  logic              pix_ce,
   input  logic              line_start,
   input  logic              blank,
   input  logic [ADDR_W-1:0] vid_addr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_req,
   input  logic              cpu_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_sel,
   output logic              ram_we,
   output logic              code_ld,
   output logic              attr_ld,
   output logic              shift_ld_n,
   output logic              cpu_ack,
   output logic              n_wait
);

   // CPU access states. DONE holds the ack until the CPU drops its request,
   // so one request can never receive two accesses.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } cpu_st_t;

   cpu_st_t           st_q;
   cpu_st_t           st_d;
   logic [2:0]        phase_q;
   logic [2:0]        np;
   logic              cpu_elig;
   logic              grant;
   logic [ADDR_W-1:0] cpu_addr_q;
   logic              cpu_we_q;
   logic              code_ld_q;
   logic              attr_ld_q;
   logic              shift_ld_n_q;

   // Phase the cell moves to at the next pix_ce edge; line_start realigns the cell to phase 0.
   always_comb begin
      np = line_start ? 3'd0 : phase_q + 3'd1;
   end

   // CPU eligibility of the upcoming phase. Phase 7 is reserved for the shifter
   // load, so a grant into phase 6 always finishes at the 6->7 edge.
   always_comb begin
      cpu_elig = (np >= 3'd4) && (np <= 3'd6);
`ifdef FREE_BLANK_ACCESS_EN
      if (blank) begin
         cpu_elig = 1'b1;
      end
`endif
   end

   // A grant is only considered from IDLE, on a pixel edge, into an eligible phase.
   always_comb begin
      grant = (st_q == ST_IDLE) && pix_ce && cpu_req && cpu_elig;
   end

   // Phase counter: advances only on pixel clock enables.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         phase_q <= 3'd0;
      end else if (pix_ce) begin
         phase_q <= np;
      end
   end

   // Latch strobes: one clk pulse after leaving phase 1 (code) or phase 3 (attribute), none while blanking.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         code_ld_q <= 1'b0;
         attr_ld_q <= 1'b0;
      end else begin
         code_ld_q <= pix_ce && (phase_q == 3'd1) && !blank;
         attr_ld_q <= pix_ce && (phase_q == 3'd3) && !blank;
      end
   end

   // Shifter load: low for the whole of phase 7, with blank sampled at the edge entering each phase.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         shift_ld_n_q <= 1'b1;
      end else if (pix_ce) begin
         shift_ld_n_q <= !((np == 3'd7) && !blank);
      end
   end

   // CPU address and direction are captured at grant, so bus changes during the access are ignored.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         cpu_addr_q <= '0;
         cpu_we_q   <= 1'b0;
      end else if (grant) begin
         cpu_addr_q <= cpu_addr;
         cpu_we_q   <= cpu_we;
      end
   end

   // CPU FSM state register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         st_q <= ST_IDLE;
      end else begin
         st_q <= st_d;
      end
   end

   // CPU FSM next state: the access always spans exactly one pixel period, regardless of blank or line_start.
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: begin
            if (grant) begin
               st_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (pix_ce) begin
               st_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!cpu_req) begin
               st_d = ST_IDLE;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // CPU FSM outputs, decoded from the state register so that reset clears them without a clk edge.
   always_comb begin
      ram_sel  = (st_q == ST_ACCESS);
      ram_we   = (st_q == ST_ACCESS) && cpu_we_q;
      cpu_ack  = (st_q == ST_DONE);
      n_wait   = !(cpu_req && (st_q != ST_DONE));
      ram_addr = (st_q == ST_ACCESS) ? cpu_addr_q : vid_addr;
   end

   // Strobe registers drive the outputs directly.
   always_comb begin
      code_ld    = code_ld_q;
      attr_ld    = attr_ld_q;
      shift_ld_n = shift_ld_n_q;
   end

endmodule
